// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, instruction-memory addressing and a
// 2-entry prefetch buffer presented to decode over a valid/ready handshake.
module fetch_unit #(
   parameter int unsigned        ADDR_W   = 8,
   parameter int unsigned        DATA_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = 8'h00
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [DATA_W-1:0] imem_inst,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_inst,
   output logic [ADDR_W-1:0] out_pc,
   output logic [ADDR_W-1:0] out_pc_plus4
);

   localparam logic [DATA_W-1:0] Nop       = DATA_W'(32'h0000_0013);
   localparam logic [ADDR_W-1:0] AlignMask = ~ADDR_W'(3);
   localparam logic [ADDR_W-1:0] Four      = ADDR_W'(4);

   typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              rd_ptr_q, rd_ptr_d;
   logic              wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] ent_pc_q   [2];
   logic [DATA_W-1:0] ent_inst_q [2];
   logic              pop, push;

   assign imem_addr    = pc_q & AlignMask;
   assign out_valid    = (state_q != StEmpty);
   assign out_inst     = out_valid ? ent_inst_q[rd_ptr_q] : Nop;
   assign out_pc       = out_valid ? ent_pc_q[rd_ptr_q] : '0;
   assign out_pc_plus4 = out_pc + Four;

   always_comb begin
      pop      = out_valid & out_ready;
      push     = ~redirect_valid & ((state_q != StFull) | pop);
      state_d  = state_q;
      pc_d     = pc_q;
      rd_ptr_d = rd_ptr_q ^ pop;
      wr_ptr_d = wr_ptr_q ^ push;

      if (push) begin
         pc_d = pc_q + Four;
      end

      unique case (state_q)
         StEmpty: if (push)         state_d = StOne;
         StOne:   if (push && !pop) state_d = StFull;
                  else if (!push && pop) state_d = StEmpty;
         StFull:  if (!push && pop) state_d = StOne;
         default: state_d = StEmpty;
      endcase

      // Redirect wins: a same-cycle pop is consumed, everything else is dropped.
      if (redirect_valid) begin
         state_d  = StEmpty;
         rd_ptr_d = 1'b0;
         wr_ptr_d = 1'b0;
         pc_d     = redirect_pc & AlignMask;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StEmpty;
         pc_q     <= RESET_PC;
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            ent_pc_q[i]   <= '0;
            ent_inst_q[i] <= Nop;
         end
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         if (push) begin
            ent_pc_q[wr_ptr_q]   <= imem_addr;
            ent_inst_q[wr_ptr_q] <= imem_inst;
         end
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory word i holds 0xA0+i, so the
// instruction at byte address a is 0xA0 + a/4.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  imem_addr;
   logic [31:0] imem_inst;
   logic        redirect_valid;
   logic [7:0]  redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_inst;
   logic [7:0]  out_pc;
   logic [7:0]  out_pc_plus4;

   logic [31:0] mem [64];
   int          n_checks = 0;
   int          n_fail   = 0;

   always #5 clk = ~clk;

   assign imem_inst = mem[imem_addr[7:2]];

   fetch_unit #(
      .ADDR_W  (8),
      .DATA_W  (32),
      .RESET_PC(8'h00)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .imem_addr     (imem_addr),
      .imem_inst     (imem_inst),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_inst      (out_inst),
      .out_pc        (out_pc),
      .out_pc_plus4  (out_pc_plus4)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_head(input string tag, input logic v, input logic [31:0] inst,
                             input logic [7:0] pc);
      check({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
      check({tag, ".inst"}, out_inst, inst);
      check({tag, ".pc"}, {24'd0, out_pc}, {24'd0, pc});
      check({tag, ".pc4"}, {24'd0, out_pc_plus4}, {24'd0, pc + 8'd4});
   endtask

   task automatic check_addr(input string tag, input logic [7:0] a);
      check(tag, {24'd0, imem_addr}, {24'd0, a});
   endtask

   // Sample 1 time unit after the rising edge; inputs also change there.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'hA0 + i;
      rst_n          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 8'h00;
      out_ready      = 1'b1;

      // Reset state
      step();
      check_head("rst", 1'b0, 32'h13, 8'h00);
      check_addr("rst.addr", 8'h00);
      rst_n = 1'b1;

      // Streaming with out_ready=1
      step(); check_head("s1", 1'b1, 32'hA0, 8'h00); check_addr("s1.addr", 8'h04);
      step(); check_head("s2", 1'b1, 32'hA1, 8'h04);
      step(); check_head("s3", 1'b1, 32'hA2, 8'h08);
      step(); check_head("s4", 1'b1, 32'hA3, 8'h0C);

      // Back-pressure: hold out_ready low for 4 cycles after first valid
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      step(); check_head("b1", 1'b1, 32'hA0, 8'h00);
      out_ready = 1'b0;
      step(); check_addr("b2.addr", 8'h08); check_head("b2", 1'b1, 32'hA0, 8'h00);
      step(); check_addr("b3.addr", 8'h08);
      step(); check_addr("b4.addr", 8'h08);
      step(); check_addr("b5.addr", 8'h08); check_head("b5", 1'b1, 32'hA0, 8'h00);
      out_ready = 1'b1;
      step(); check_head("b6", 1'b1, 32'hA1, 8'h04); check_addr("b6.addr", 8'h0C);
      step(); check_head("b7", 1'b1, 32'hA2, 8'h08);

      // Redirect + pop with buffer full (A2 consumed, A3 dropped), misaligned target
      redirect_valid = 1'b1;
      redirect_pc    = 8'h3E;
      step(); check_head("r1", 1'b0, 32'h13, 8'h00); check_addr("r1.addr", 8'h3C);
      redirect_valid = 1'b0;
      step(); check_head("r2", 1'b1, 32'hAF, 8'h3C);
      step(); check_head("r3", 1'b1, 32'hB0, 8'h40);

      // Redirect from count=1 to the top of the address space, then wrap
      redirect_valid = 1'b1;
      redirect_pc    = 8'hFC;
      step(); check_head("w0", 1'b0, 32'h13, 8'h00); check_addr("w0.addr", 8'hFC);
      redirect_valid = 1'b0;
      step(); check_head("w1", 1'b1, 32'hDF, 8'hFC);
      check("w1.pc4_wrap", {24'd0, out_pc_plus4}, 32'h00);
      step(); check_head("w2", 1'b1, 32'hA0, 8'h00);
      check("w2.pc4", {24'd0, out_pc_plus4}, 32'h04);

      // Fill to count=2, then assert reset asynchronously mid-cycle
      out_ready = 1'b0;
      step(); check_head("f1", 1'b1, 32'hA0, 8'h00); check_addr("f1.addr", 8'h08);
      #2;
      rst_n          = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 8'h80;
      #1;
      check_head("ar", 1'b0, 32'h13, 8'h00);
      check_addr("ar.addr", 8'h00);
      step(); check_addr("ar.redir_ignored", 8'h00); check_head("ar2", 1'b0, 32'h13, 8'h00);
      redirect_valid = 1'b0;
      out_ready      = 1'b1;
      rst_n          = 1'b1;
      step(); check_head("rr1", 1'b1, 32'hA0, 8'h00);
      step(); check_head("rr2", 1'b1, 32'hA1, 8'h04);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage directly upstream of the instruction memory and downstream-facing to decode. Holds the program counter, drives the memory's 8-bit byte address, captures the returned 32-bit word with its PC into a 2-entry prefetch buffer, and presents it to decode over a valid/ready handshake. Branch/jump redirects from execute flush the buffer and reload the PC.

## Interface
- ADDR_W, 8, PC/byte-address width; matches instruction memory address port
- DATA_W, 32, instruction width
- RESET_PC, 8'h00, PC value loaded on reset
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- imem_addr  output  ADDR_W  byte address to instruction memory (word index = addr/4)
- imem_inst  input  DATA_W  combinational read data for imem_addr, valid same cycle
- redirect_valid  input  1  execute requests PC change this cycle
- redirect_pc  input  ADDR_W  redirect target; bits [1:0] ignored (forced 0)
- out_valid  output  1  buffer head holds a valid instruction
- out_ready  input  1  decode accepts head this cycle
- out_inst  output  DATA_W  head instruction; 32'h00000013 (NOP) when out_valid=0
- out_pc  output  ADDR_W  PC of head instruction; 0 when out_valid=0
- out_pc_plus4  output  ADDR_W  out_pc+4, modulo 2^ADDR_W

## Operation
- Registers: pc[ADDR_W-1:0], two buffer entries {pc, inst}, rd_ptr (1 bit), wr_ptr (1 bit), count (0..2).
- imem_addr = pc, combinational from the register; bits [1:0] always 0.
- pop = out_valid & out_ready.
- push = ~redirect_valid & (count<2 | pop). On push: entry[wr_ptr] <= {pc, imem_inst}; wr_ptr toggles; pc <= pc+4.
- pop: rd_ptr toggles.
- count_next = count + push - pop when no redirect.
- Redirect (highest priority): count<=0, rd_ptr<=0, wr_ptr<=0, pc<={redirect_pc[ADDR_W-1:2],2'b00}, no push. A pop in the same cycle still completes (decode consumed the head); all other buffered entries are discarded.
- Buffer states: EMPTY (count 0, out_valid=0), ONE (count 1), FULL (count 2). Transitions: EMPTY->ONE on push; ONE->FULL on push & ~pop; ONE->EMPTY on pop & ~push; FULL->ONE on pop & ~push; FULL holds with push & pop; any->EMPTY on redirect.
- In FULL without pop: pc holds, imem_addr stable, no fetch.
- PC arithmetic is unsigned, ADDR_W bits; 0xFC+4 wraps to 0x00. No halt or bounds check.
- out_valid = (count!=0); head = entry[rd_ptr].

## Timing
- Reset (async assert, sync-released use on next edge): pc=RESET_PC, count=0, pointers=0, entries cleared to {0, 32'h00000013}; out_valid=0, out_inst=32'h00000013, out_pc=0, out_pc_plus4=4.
- Fetch-to-output latency: instruction at PC fetched in cycle N is at the head, out_valid=1, in cycle N+1.
- First cycle after reset release: imem_addr=RESET_PC, push occurs; out_valid=1 on next cycle.
- Redirect asserted in cycle N: out_valid=0 in N+1, imem_addr=target in N+1; target instruction at head in N+2 (2-cycle redirect penalty).
- Steady-state with out_ready held 1: one instruction per cycle, count oscillates between 1 and 1 (push & pop each cycle).
- out_ready low for k cycles starting from count=1: buffer reaches FULL after 1 cycle, then fetch stalls; on out_ready return, throughput resumes with no bubble.
- redirect_valid ignored while rst_n=0; reset mid-operation discards all buffered entries immediately.

## Test plan
- Reset, RESET_PC=0, out_ready=1, memory words 0..3 = 0xA0,0xA1,0xA2,0xA3 -> out_inst 0xA0,0xA1,0xA2,0xA3 on consecutive cycles from cycle 1, out_pc 0x00,0x04,0x08,0x0C.
- Same program, out_ready=0 for 4 cycles after first valid -> count reaches 2, imem_addr holds 0x08; on release outputs 0xA0,0xA1,0xA2 with no gap or duplicate.
- Redirect to 0x3E in steady state -> out_valid=0 one cycle, next head out_pc=0x3C, out_inst=mem[15]; pre-redirect buffered entries never appear.
- Redirect and pop in same cycle with count=2 -> popped entry counts as consumed, second entry dropped, count=0 next cycle.
- pc=0xFC with out_ready=1 -> out_pc 0xFC then 0x00, out_pc_plus4 0x00 then 0x04.
- Assert rst_n=0 mid-stream with count=2 -> out_valid=0, out_inst=0x00000013, imem_addr=RESET_PC asynchronously.
